// File: rtl/div_pkg.sv
// Shared constants and state encoding for the multi-cycle divider.
// Imported by the EX stage and the divider itself.
package div_pkg;

  localparam logic [1:0] DIV_IDLE   = 2'd0;
  localparam logic [1:0] DIV_BYZERO = 2'd1;
  localparam logic [1:0] DIV_ON     = 2'd2;
  localparam logic [1:0] DIV_END    = 2'd3;

  localparam int DIV_DEFAULT_WIDTH = 32;

  localparam logic DIV_START = 1'b1;
  localparam logic DIV_STOP  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE   = DIV_IDLE,
    S_BYZERO = DIV_BYZERO,
    S_ON     = DIV_ON,
    S_END    = DIV_END
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring division iteration on an already shifted
// partial remainder; purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_o
);

  logic [WIDTH:0] diff;

  // Top bit of the difference is the borrow.
  assign diff  = rem_i - {1'b0, divisor_i};
  assign q_o   = ~diff[WIDTH];
  assign rem_o = q_o ? diff[WIDTH-1:0] : rem_i[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU.
// result_o = {remainder, quotient}.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

  div_state_e state, state_nx;

  logic [CW-1:0]    cnt;
  logic             sdiv;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] rem_nx;
  logic             q_bit;
  logic [WIDTH-1:0] op1_abs;
  logic [WIDTH-1:0] op2_abs;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;
  logic             done;
  logic             accept;

  assign done   = (cnt == CNT_LAST);
  assign accept = start_i && !annul_i;
  assign busy_o = (state == S_BYZERO) || (state == S_ON);

  assign op1_abs = (signed_div_i && opdata1_i[WIDTH-1])
                 ? -opdata1_i : opdata1_i;
  assign op2_abs = (signed_div_i && opdata2_i[WIDTH-1])
                 ? -opdata2_i : opdata2_i;

  assign quo_fix = (sdiv && (neg_a ^ neg_b)) ? -quo : quo;
  assign rem_fix = (sdiv && neg_a) ? -rem : rem;

  // quo starts as the dividend; its MSB feeds the remainder
  // while quotient bits shift in at the bottom.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     ({rem, quo[WIDTH-1]}),
    .divisor_i (divisor),
    .rem_o     (rem_nx),
    .q_o       (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (accept)
          state_nx = (opdata2_i == '0) ? S_BYZERO : S_ON;
      end
      S_BYZERO: state_nx = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)   state_nx = S_IDLE;
        else if (done) state_nx = S_END;
      end
      S_END: begin
        if (!start_i) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      sdiv     <= 1'b0;
      neg_a    <= 1'b0;
      neg_b    <= 1'b0;
      quo      <= '0;
      divisor  <= '0;
      rem      <= '0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          ready_o  <= 1'b0;
          result_o <= '0;
          if (accept && opdata2_i != '0) begin
            sdiv    <= signed_div_i;
            neg_a   <= signed_div_i & opdata1_i[WIDTH-1];
            neg_b   <= signed_div_i & opdata2_i[WIDTH-1];
            quo     <= op1_abs;
            divisor <= op2_abs;
            rem     <= '0;
            cnt     <= '0;
          end
        end
        S_BYZERO: begin
          if (!annul_i) begin
            result_o <= '0;
            ready_o  <= 1'b1;
          end
        end
        S_ON: begin
          if (!annul_i) begin
            if (done) begin
              result_o <= {rem_fix, quo_fix};
              ready_o  <= 1'b1;
            end else begin
              rem <= rem_nx;
              quo <= {quo[WIDTH-2:0], q_bit};
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_END: begin
          if (!start_i) begin
            ready_o  <= 1'b0;
            result_o <= '0;
          end
        end
        default: begin
          ready_o  <= 1'b0;
          result_o <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit at WIDTH=32 and WIDTH=8.
// Hand vectors, corner sequences and a random sweep vs a model.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst32, rst8;
  logic        sd32, sd8;
  logic [31:0] a32, b32;
  logic [7:0]  a8, b8;
  logic        st32, st8, an32, an8;
  logic [63:0] res32;
  logic [15:0] res8;
  logic        rdy32, rdy8, busy32, busy8;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32)) u32 (
    .clk          (clk),
    .rst          (rst32),
    .signed_div_i (sd32),
    .opdata1_i    (a32),
    .opdata2_i    (b32),
    .start_i      (st32),
    .annul_i      (an32),
    .result_o     (res32),
    .ready_o      (rdy32),
    .busy_o       (busy32)
  );

  div_unit #(.WIDTH(8)) u8 (
    .clk          (clk),
    .rst          (rst8),
    .signed_div_i (sd8),
    .opdata1_i    (a8),
    .opdata2_i    (b8),
    .start_i      (st8),
    .annul_i      (an8),
    .result_o     (res8),
    .ready_o      (rdy8),
    .busy_o       (busy8)
  );

  typedef struct {
    logic        sd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    string       nm;
  } vec_t;

  vec_t tv[8];

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] res_of(input int w);
    return (w == 32) ? res32 : {48'd0, res8};
  endfunction

  function automatic logic rdy_of(input int w);
    return (w == 32) ? rdy32 : rdy8;
  endfunction

  function automatic logic busy_of(input int w);
    return (w == 32) ? busy32 : busy8;
  endfunction

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Truncating division done on 64-bit integers, so the
  // most-negative / -1 case cannot overflow the model.
  function automatic void ref_div(input int w, input logic sd,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] q,
                                  output logic [31:0] r);
    logic [31:0] m;
    longint sa, sb, lq, lr;
    m = mask_of(w);
    a = a & m;
    b = b & m;
    q = '0;
    r = '0;
    if (b == '0) return;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (sd && a[w-1]) sa = sa - (longint'(1) << w);
    if (sd && b[w-1]) sb = sb - (longint'(1) << w);
    lq = sa / sb;
    lr = sa % sb;
    q = lq[31:0] & m;
    r = lr[31:0] & m;
  endfunction

  task automatic drive(input int w, input logic sd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic st, input logic an);
    if (w == 32) begin
      sd32 = sd; a32 = a; b32 = b; st32 = st; an32 = an;
    end else begin
      sd8 = sd; a8 = a[7:0]; b8 = b[7:0]; st8 = st; an8 = an;
    end
  endtask

  task automatic do_div(input int w, input logic sd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er,
                        input string nm, input bit scramble);
    int n, lat;
    bit got;
    logic [63:0] exp_res;
    lat = ((b & mask_of(w)) == '0) ? 2 : w + 2;
    exp_res = (w == 32) ? {er, eq}
                        : {48'd0, er[7:0], eq[7:0]};
    drive(w, sd, a, b, 1'b1, 1'b0);
    n = 0;
    got = 1'b0;
    while (!got && n < w + 8) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        check({nm, " busy"}, 64'(busy_of(w)), 64'd1);
        if (scramble)
          drive(w, ~sd, $urandom, $urandom | 32'd1, 1'b1, 1'b0);
      end
      got = rdy_of(w);
    end
    check({nm, " latency"}, 64'(n), 64'(lat));
    check({nm, " result"}, res_of(w), exp_res);
    drive(w, sd, a, b, 1'b1, 1'b1);
    @(posedge clk); #1;
    check({nm, " hold rdy"}, 64'(rdy_of(w)), 64'd1);
    check({nm, " hold res"}, res_of(w), exp_res);
    drive(w, sd, a, b, 1'b0, 1'b0);
    @(posedge clk); #1;
    check({nm, " drop rdy"}, 64'(rdy_of(w)), 64'd0);
    check({nm, " drop res"}, res_of(w), 64'd0);
    check({nm, " drop busy"}, 64'(busy_of(w)), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q, r, a, b;
    logic sd;
    int w;

    tv[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         "u100/7"};
    tv[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, "s-7/2"};
    tv[2] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         "s7/-2"};
    tv[3] = '{1'b1, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         "s/0"};
    tv[4] = '{1'b0, 32'hFFFF_FFFF, 32'd0,         32'd0,         32'd0,         "u/0"};
    tv[5] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         "s ovf"};
    tv[6] = '{1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         "u max/1"};
    tv[7] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, "s-100/-7"};

    rst32 = 1'b1;
    rst8  = 1'b1;
    drive(32, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(8,  1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst32 = 1'b0;
    rst8  = 1'b0;
    @(posedge clk); #1;
    check("reset res32",  res32, 64'd0);
    check("reset rdy32",  64'(rdy32), 64'd0);
    check("reset busy32", 64'(busy32), 64'd0);
    check("reset res8",   64'(res8), 64'd0);
    check("reset rdy8",   64'(rdy8), 64'd0);

    for (int i = 0; i < 8; i++)
      do_div(32, tv[i].sd, tv[i].a, tv[i].b, tv[i].q, tv[i].r,
             tv[i].nm, 1'b0);

    // Annul partway through, then a fresh division.
    drive(32, 1'b0, 32'd100, 32'd7, 1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (rdy32) check("annul early rdy", 64'(rdy32), 64'd0);
    end
    check("annul pre busy", 64'(busy32), 64'd1);
    drive(32, 1'b0, 32'd100, 32'd7, 1'b1, 1'b1);
    @(posedge clk); #1;
    check("annul busy", 64'(busy32), 64'd0);
    check("annul rdy",  64'(rdy32), 64'd0);
    drive(32, 1'b0, 32'd100, 32'd7, 1'b0, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      check("annul idle rdy", 64'(rdy32), 64'd0);
    end
    do_div(32, 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, "post annul", 1'b0);

    // Narrow build: plain, reset mid-division, operand scramble.
    do_div(8, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, "w8 200/3", 1'b0);
    drive(8, 1'b0, 32'd200, 32'd3, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst8 = 1'b1;
    @(posedge clk); #1;
    check("w8 rst busy", 64'(busy8), 64'd0);
    check("w8 rst rdy",  64'(rdy8), 64'd0);
    check("w8 rst res",  64'(res8), 64'd0);
    rst8 = 1'b0;
    drive(8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    do_div(8, 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, "w8 scramble", 1'b1);
    do_div(8, 1'b1, 32'h80, 32'hFF, 32'h80, 32'd0, "w8 ovf", 1'b0);

    for (int i = 0; i < 40; i++) begin
      w  = (i % 2 == 0) ? 32 : 8;
      sd = 1'($urandom_range(0, 1));
      a  = $urandom;
      b  = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) b = '0;
      ref_div(w, sd, a, b, q, r);
      do_div(w, sd, a, b, q, r, $sformatf("rand%0d", i),
             1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
